// File: rtl/pc_pkg.sv
// pc_pkg: shared action encoding and default widths for the program counter with return-address stack.
package pc_pkg;
  localparam int PC_AW        = 16;
  localparam int PC_DISP_W    = 8;
  localparam int PC_RAS_DEPTH = 4;
  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_BR   = 3'd2,
    PC_JMP  = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5
  } pc_act_e;
endpackage

// File: rtl/pc_ras.sv
// pc_ras: LIFO return-address stack with count; PC_RAS_CIRC_EN makes a push while full overwrite the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int AW    = PC_AW,
  parameter int DEPTH = PC_RAS_DEPTH
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [AW-1:0] stk [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          pop_ok;
  logic          wr_ok;
  assign empty  = cnt == '0;
  assign full   = cnt == CW'(DEPTH);
  assign rp     = wp - PW'(1);
  assign top    = stk[rp];
  assign pop_ok = pop & ~empty;
`ifdef PC_RAS_CIRC_EN
  // Write pointer wraps, so a push while full lands on the oldest slot.
  assign wr_ok  = push & ~pop_ok;
`else
  assign wr_ok  = push & ~pop_ok & ~full;
`endif
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wp  <= '0;
      cnt <= '0;
    end else if (pop_ok) begin
      wp  <= rp;
      cnt <= cnt - CW'(1);
    end else if (wr_ok) begin
      wp  <= wp + PW'(1);
      cnt <= full ? cnt : cnt + CW'(1);
    end
  always_ff @(posedge clk)
    if (reset && wr_ok) stk[wp] <= push_data;
endmodule

// File: rtl/pc_ras_seq.sv
// pc_ras_seq: fetch-stage PC with relative branch, jump, call/return over a hardware RAS and sticky stack faults.
// Define PC_RAS_CIRC_EN for a circular return-address stack.
module pc_ras_seq
  import pc_pkg::*;
#(
  parameter int            AW        = PC_AW,
  parameter int            DISP_W    = PC_DISP_W,
  parameter int            RAS_DEPTH = PC_RAS_DEPTH,
  parameter logic [AW-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pc_en,
  input  logic              br_en,
  input  logic [DISP_W-1:0] br_disp,
  input  logic              jmp_en,
  input  logic              call_en,
  input  logic              ret_en,
  input  logic [AW-1:0]     jmp_addr,
  input  logic              err_clr,
  output logic [AW-1:0]     pc,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_ovf,
  output logic              ras_unf
);
  pc_act_e       act;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] disp_ext;
  logic [AW-1:0] ras_top;
  logic [AW-1:0] pc_nxt;
  logic          ovf_set;
  logic          unf_set;
  assign pc_inc   = pc + AW'(1);
  assign disp_ext = AW'($signed(br_disp));
  always_comb begin
    act     = !pc_en ? PC_HOLD : ret_en ? PC_RET : call_en ? PC_CALL :
              jmp_en ? PC_JMP : br_en ? PC_BR : PC_INC;
    pc_nxt  = act == PC_RET  ? (ras_empty ? pc_inc : ras_top) :
              act == PC_CALL || act == PC_JMP ? jmp_addr :
              act == PC_BR   ? pc + disp_ext :
              act == PC_INC  ? pc_inc : pc;
    ovf_set = act == PC_CALL && ras_full;
    unf_set = act == PC_RET && ras_empty;
  end
  pc_ras #(.AW(AW), .DEPTH(RAS_DEPTH)) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (act == PC_CALL),
    .pop      (act == PC_RET),
    .push_data(pc_inc),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );
  // A fault arriving with err_clr stays visible.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pc      <= RESET_PC;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      ras_ovf <= ovf_set | (ras_ovf & ~err_clr);
      ras_unf <= unf_set | (ras_unf & ~err_clr);
    end
endmodule

// File: tb/tb_pc_ras_seq.sv
// tb_pc_ras_seq: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_pc_ras_seq;
  typedef struct {
    logic [15:0] pc;
    logic        e, f, o, u;
    string       nm;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pc_en = 1'b0, br_en = 1'b0, jmp_en = 1'b0, call_en = 1'b0, ret_en = 1'b0, err_clr = 1'b0;
  logic [7:0]  br_disp = '0;
  logic [15:0] jmp_addr = '0;
  logic [15:0] pc;
  logic        ras_empty, ras_full, ras_ovf, ras_unf;
  exp_t        q[$];
  exp_t        x;
  event        chk_ev;
  int          n_chk = 0;
  int          n_fail = 0;
  pc_ras_seq dut (
    .clk(clk), .reset(rst_n), .pc_en(pc_en), .br_en(br_en), .br_disp(br_disp),
    .jmp_en(jmp_en), .call_en(call_en), .ret_en(ret_en), .jmp_addr(jmp_addr),
    .err_clr(err_clr), .pc(pc), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf)
  );
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk or chk_ev);
    #1;
    if (q.size() != 0) begin
      x = q.pop_front();
      n_chk++;
      if ({pc, ras_empty, ras_full, ras_ovf, ras_unf} !== {x.pc, x.e, x.f, x.o, x.u}) begin
        n_fail++;
        $display("FAIL %s: got pc=%h e=%b f=%b ovf=%b unf=%b, expected pc=%h e=%b f=%b ovf=%b unf=%b",
                 x.nm, pc, ras_empty, ras_full, ras_ovf, ras_unf, x.pc, x.e, x.f, x.o, x.u);
      end
    end
  end
  task automatic step(input string nm, input logic en, ret, call, jmp, br, input logic [7:0] disp,
                      input logic [15:0] addr, input logic clr,
                      input logic [15:0] epc, input logic ee, ef, eo, eu);
    @(negedge clk);
    pc_en = en; ret_en = ret; call_en = call; jmp_en = jmp; br_en = br;
    br_disp = disp; jmp_addr = addr; err_clr = clr;
    q.push_back('{epc, ee, ef, eo, eu, nm});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    rst_n = 1'b1;
    step("rst_state", 0,0,0,0,0, 8'h00, 16'h0000, 0, 16'h0000, 1,0,0,0);
    step("pre_call1", 1,0,1,0,0, 8'h00, 16'h0040, 0, 16'h0040, 0,0,0,0);
    step("pre_call2", 1,0,1,0,0, 8'h00, 16'h0042, 0, 16'h0042, 0,0,0,0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    pc_en = 1'b0; call_en = 1'b0;
    q.push_back('{16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, "async_rst"});
    ->chk_ev;
    @(negedge clk);
    rst_n = 1'b1;
    step("inc1", 1,0,0,0,0, 8'h00, 16'h0000, 0, 16'h0001, 1,0,0,0);
    step("inc2", 1,0,0,0,0, 8'h00, 16'h0000, 0, 16'h0002, 1,0,0,0);
    step("inc3", 1,0,0,0,0, 8'h00, 16'h0000, 0, 16'h0003, 1,0,0,0);
    step("jmp10",    1,0,0,1,0, 8'h00, 16'h0010, 0, 16'h0010, 1,0,0,0);
    step("br_neg2",  1,0,0,0,1, 8'hFE, 16'h0000, 0, 16'h000E, 1,0,0,0);
    step("br_pos5",  1,0,0,0,1, 8'h05, 16'h0000, 0, 16'h0013, 1,0,0,0);
    step("br_zero",  1,0,0,0,1, 8'h00, 16'h0000, 0, 16'h0013, 1,0,0,0);
    step("br_min",   1,0,0,0,1, 8'h80, 16'h0000, 0, 16'hFF93, 1,0,0,0);
    step("jmpFFFF",  1,0,0,1,0, 8'h00, 16'hFFFF, 0, 16'hFFFF, 1,0,0,0);
    step("inc_wrap", 1,0,0,0,0, 8'h00, 16'h0000, 0, 16'h0000, 1,0,0,0);
    step("jmp20",    1,0,0,1,0, 8'h00, 16'h0020, 0, 16'h0020, 1,0,0,0);
    step("call100",  1,0,1,0,0, 8'h00, 16'h0100, 0, 16'h0100, 0,0,0,0);
    step("call200",  1,0,1,0,0, 8'h00, 16'h0200, 0, 16'h0200, 0,0,0,0);
    step("ret101",   1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0101, 0,0,0,0);
    step("ret021",   1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0021, 1,0,0,0);
    step("c5_1", 1,0,1,0,0, 8'h00, 16'h0300, 0, 16'h0300, 0,0,0,0);
    step("c5_2", 1,0,1,0,0, 8'h00, 16'h0400, 0, 16'h0400, 0,0,0,0);
    step("c5_3", 1,0,1,0,0, 8'h00, 16'h0500, 0, 16'h0500, 0,0,0,0);
    step("c5_4", 1,0,1,0,0, 8'h00, 16'h0600, 0, 16'h0600, 0,1,0,0);
    step("c5_5", 1,0,1,0,0, 8'h00, 16'h0700, 0, 16'h0700, 0,1,1,0);
`ifdef PC_RAS_CIRC_EN
    step("r4_1", 1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0601, 0,0,1,0);
    step("r4_2", 1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0501, 0,0,1,0);
    step("r4_3", 1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0401, 0,0,1,0);
    step("r4_4", 1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0301, 1,0,1,0);
    step("ovf_clr", 0,0,0,0,0, 8'h00, 16'h0000, 1, 16'h0301, 1,0,0,0);
    step("jmp30",   1,0,0,1,0, 8'h00, 16'h0030, 0, 16'h0030, 1,0,0,0);
`else
    step("r4_1", 1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0501, 0,0,1,0);
    step("r4_2", 1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0401, 0,0,1,0);
    step("r4_3", 1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0301, 0,0,1,0);
    step("r4_4", 1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0022, 1,0,1,0);
    step("ovf_clr", 0,0,0,0,0, 8'h00, 16'h0000, 1, 16'h0022, 1,0,0,0);
    step("jmp30",   1,0,0,1,0, 8'h00, 16'h0030, 0, 16'h0030, 1,0,0,0);
`endif
    step("ret_empty",   1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0031, 1,0,0,1);
    step("unf_clr",     0,0,0,0,0, 8'h00, 16'h0000, 1, 16'h0031, 1,0,0,0);
    step("unf_clr_set", 1,1,0,0,0, 8'h00, 16'h0000, 1, 16'h0032, 1,0,0,1);
    step("unf_clr2",    0,0,0,0,0, 8'h00, 16'h0000, 1, 16'h0032, 1,0,0,0);
    step("jmp_over_br", 1,0,0,1,1, 8'h05, 16'h0054, 0, 16'h0054, 1,0,0,0);
    step("call80",      1,0,1,0,0, 8'h00, 16'h0080, 0, 16'h0080, 0,0,0,0);
    step("ret_prio",    1,1,1,0,1, 8'h03, 16'h0999, 0, 16'h0055, 1,0,0,0);
    step("no_push",     1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0056, 1,0,0,1);
    step("call90",      1,0,1,0,0, 8'h00, 16'h0090, 1, 16'h0090, 0,0,0,0);
    step("stall_call",  0,0,1,0,0, 8'h00, 16'h0AAA, 0, 16'h0090, 0,0,0,0);
    step("stall_ret",   0,1,0,1,1, 8'h07, 16'h0BBB, 0, 16'h0090, 0,0,0,0);
    step("ret057",      1,1,0,0,0, 8'h00, 16'h0000, 0, 16'h0057, 1,0,0,0);
    @(negedge clk);
    pc_en = 1'b0; ret_en = 1'b0; call_en = 1'b0; jmp_en = 1'b0; br_en = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    #3;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pc_ras_seq.md
Name: pc_ras_seq

Overview:
- Parametrised program counter that succeeds the fixed 16-bit PC. Adds a configurable address width and a signed relative-branch displacement, plus absolute jump, call/return and a hardware return-address stack (RAS).
- Sits in the fetch stage: drives the instruction-memory address; control inputs come from the decoder/controller FSM.
- Stack status flags feed the processor's fault/status register.

Parameters:
- AW, 16, PC/address width in bits (>= 8).
- DISP_W, 8, relative-branch displacement width, two's complement (2 .. AW).
- RAS_DEPTH, 4, number of return-address stack entries; power of two, >= 2.
- RESET_PC, 0, value loaded into pc on reset (AW bits).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- pc_en  in  1  advance enable; 0 = hold pc and stack (stall).
- br_en  in  1  relative branch this cycle.
- br_disp  in  DISP_W  signed displacement added to current pc.
- jmp_en  in  1  absolute jump to jmp_addr.
- call_en  in  1  call: push pc+1, jump to jmp_addr.
- ret_en  in  1  return: pop stack into pc.
- jmp_addr  in  AW  absolute target for jump/call.
- err_clr  in  1  synchronous clear of sticky error flags.
- pc  out  AW  current program counter (registered).
- ras_empty  out  1  stack holds 0 entries.
- ras_full  out  1  stack holds RAS_DEPTH entries.
- ras_ovf  out  1  sticky: push attempted while full.
- ras_unf  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset (async, reset==0): pc=RESET_PC, stack count=0, ras_empty=1, ras_full=0, ras_ovf=0, ras_unf=0. Applies mid-operation, discarding any in-flight push/pop.
- pc_en==0: pc, stack and flags hold; err_clr still acts.
- pc_en==1, priority ret_en > call_en > jmp_en > br_en > increment; lower-priority requests in the same cycle are ignored.
- Increment: pc <= pc+1, modulo 2^AW.
- Branch: pc <= pc + sign_extend(br_disp) to AW bits, modulo 2^AW. br_disp=0 gives pc unchanged (self-loop).
- Jump: pc <= jmp_addr.
- Call: push (pc+1 mod 2^AW); pc <= jmp_addr.
- Return: if stack non-empty, pc <= top and pop. If empty, pc <= pc+1, stack unchanged, ras_unf <= 1.
- Single-cycle latency: pc reflects the selected action on the edge after the request.
- Stack is LIFO with a count register (0..RAS_DEPTH). ras_empty and ras_full are decoded combinationally from the registered count.
- Sticky flags: set on the event, cleared only by reset or err_clr. If err_clr and a set event occur in the same cycle, set wins.

Optional Feature:
- Macro: PC_RAS_CIRC_EN.
- Defined: stack is circular. A call while full overwrites the oldest entry and the count stays RAS_DEPTH. ras_ovf still sets (informational).
- Undefined: a call while full still jumps, but the push is dropped, the stack is unchanged and ras_ovf <= 1.

Decomposition:
- Shared package pc_pkg:
  - action enum PC_HOLD, PC_INC, PC_BR, PC_JMP, PC_CALL, PC_RET;
  - default width constants (PC_AW=16, PC_DISP_W=8, PC_RAS_DEPTH=4).
- Sub-module pc_ras: stack storage, push/pop, count, full/empty and circular mode.
- Top: priority-encodes the action, does the arithmetic and holds the sticky flags.

Test Plan:
- Reset low async mid-cycle with pc=0x0042 and 2 stacked -> pc=0x0000, ras_empty=1 immediately; pc_en=1 for 3 cycles -> pc=0x0003.
- pc=0x0010, br_disp=8'hFE -> pc=0x000E; br_disp=8'h05 -> 0x0013; pc=0xFFFF with increment -> 0x0000.
- Nested calls: call to 0x0100 from pc=0x0020, then call to 0x0200 from 0x0100. Two rets -> pc=0x0101, then 0x0021, ras_empty=1.
- Five calls with RAS_DEPTH=4, then four rets:
  - no macro: pc sequence returns the first 4 return addresses, ras_ovf=1;
  - PC_RAS_CIRC_EN: returns the last 4.
- ret with stack empty at pc=0x0030 -> pc=0x0031, ras_unf=1. err_clr -> ras_unf=0. err_clr together with another underflow in the same cycle -> ras_unf stays 1.
- Simultaneous ret_en+call_en+br_en with one entry 0x0055 -> pc=0x0055, no push. pc_en=0 with call_en -> pc and stack unchanged.
